// File: rtl/sdram_arbiter.sv
// Arbitrates a write requester, a read requester and periodic refresh onto a single
// SDRAM command interface using a four-state handshake FSM with registered outputs.
module sdram_arbiter #(
  parameter int unsigned REFRESH_INTERVAL = 360,
  parameter int unsigned ACK_TIMEOUT      = 8
) (
  input  logic       CLK_48MHZ,
  input  logic       RESET,
  input  logic       WRITE_REQ,
  input  logic       READ_REQ,
  input  logic       SDRAM_STATUS,
  output logic [1:0] CMD_OUT,
  output logic       GRANT_WRITE,
  output logic       GRANT_READ,
  output logic       NEXT_WRITE,
  output logic       NEXT_READ,
  output logic       REFRESH_MISSED,
  output logic       TIMEOUT_ERR
);

  localparam logic [1:0] CmdNop     = 2'b00;
  localparam logic [1:0] CmdWrite   = 2'b01;
  localparam logic [1:0] CmdRead    = 2'b10;
  localparam logic [1:0] CmdRefresh = 2'b11;

  localparam int unsigned RefW = $clog2(REFRESH_INTERVAL + 1);
  localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

  state_e          state_q;
  logic [1:0]      cmd_q;
  logic [1:0]      op_q;
  logic            grant_wr_q, grant_rd_q;
  logic            next_wr_q, next_rd_q;
  logic            timeout_q;
  logic            last_rd_q;
  logic [TmoW-1:0] tmo_cnt_q;

  logic [RefW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic            pending_q, pending_d;
  logic            missed_q, missed_d;

  logic            done;
  logic            wrap;
  logic            can_eval;
  logic [1:0]      sel_cmd;

  assign done = (state_q == StWaitDone) && SDRAM_STATUS;
  assign wrap = (refresh_cnt_q == '0);
  // Hold off selection during the NEXT_* cycle so requester addresses have advanced.
  assign can_eval = (state_q == StIdle) && SDRAM_STATUS && !next_wr_q && !next_rd_q;

  always_comb begin
    sel_cmd = CmdNop;
    if (pending_q) begin
      sel_cmd = CmdRefresh;
    end else if (WRITE_REQ && READ_REQ) begin
      sel_cmd = last_rd_q ? CmdWrite : CmdRead;
    end else if (WRITE_REQ) begin
      sel_cmd = CmdWrite;
    end else if (READ_REQ) begin
      sel_cmd = CmdRead;
    end
  end

  always_comb begin
    refresh_cnt_d = wrap ? RefW'(REFRESH_INTERVAL - 1) : refresh_cnt_q - RefW'(1);
    pending_d     = pending_q;
    if (done && (op_q == CmdRefresh)) begin
      pending_d = 1'b0;
    end
    if (wrap) begin
      pending_d = 1'b1;
    end
    missed_d = missed_q | (wrap & pending_q);
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      refresh_cnt_q <= RefW'(REFRESH_INTERVAL - 1);
      pending_q     <= 1'b0;
      missed_q      <= 1'b0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      pending_q     <= pending_d;
      missed_q      <= missed_d;
    end
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      state_q    <= StIdle;
      cmd_q      <= CmdNop;
      op_q       <= CmdNop;
      grant_wr_q <= 1'b0;
      grant_rd_q <= 1'b0;
      next_wr_q  <= 1'b0;
      next_rd_q  <= 1'b0;
      timeout_q  <= 1'b0;
      last_rd_q  <= 1'b1;
      tmo_cnt_q  <= '0;
    end else begin
      cmd_q     <= CmdNop;
      next_wr_q <= 1'b0;
      next_rd_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (can_eval && (sel_cmd != CmdNop)) begin
            state_q    <= StIssue;
            cmd_q      <= sel_cmd;
            op_q       <= sel_cmd;
            grant_wr_q <= (sel_cmd == CmdWrite);
            grant_rd_q <= (sel_cmd == CmdRead);
          end
        end
        StIssue: begin
          state_q   <= StWaitBusy;
          tmo_cnt_q <= '0;
        end
        StWaitBusy: begin
          if (!SDRAM_STATUS) begin
            state_q <= StWaitDone;
          end else if (tmo_cnt_q == TmoW'(ACK_TIMEOUT - 1)) begin
            // Pending refresh and last_served stay untouched so the same request retries.
            state_q    <= StIdle;
            timeout_q  <= 1'b1;
            grant_wr_q <= 1'b0;
            grant_rd_q <= 1'b0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        StWaitDone: begin
          if (SDRAM_STATUS) begin
            state_q    <= StIdle;
            next_wr_q  <= (op_q == CmdWrite);
            next_rd_q  <= (op_q == CmdRead);
            grant_wr_q <= 1'b0;
            grant_rd_q <= 1'b0;
            if (op_q != CmdRefresh) begin
              last_rd_q <= (op_q == CmdRead);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign CMD_OUT        = cmd_q;
  assign GRANT_WRITE    = grant_wr_q;
  assign GRANT_READ     = grant_rd_q;
  assign NEXT_WRITE     = next_wr_q;
  assign NEXT_READ      = next_rd_q;
  assign REFRESH_MISSED = missed_q;
  assign TIMEOUT_ERR    = timeout_q;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter REFRESH_INTERVAL, default 360, meaning clock cycles between refresh requests (7.5 us at 48 MHz).
REQ-002 Parameter ACK_TIMEOUT, default 8, meaning cycles allowed for SDRAM_STATUS to fall after a command is issued.
REQ-003 CLK_48MHZ  in  1  system clock; all logic SHALL be on its rising edge.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 WRITE_REQ  in  1  write requester level; held high until NEXT_WRITE.
REQ-006 READ_REQ  in  1  read requester level; held high until NEXT_READ.
REQ-007 SDRAM_STATUS  in  1  interface state: 1 = idle/ready, 0 = busy.
REQ-008 CMD_OUT  out  2  command to the SDRAM interface: 00 NOP, 01 WRITE, 10 READ, 11 REFRESH.
REQ-009 GRANT_WRITE, GRANT_READ  out  1 each  address/data mux select for the granted requester.
REQ-010 NEXT_WRITE, NEXT_READ  out  1 each  one-cycle completion pulse to the requester's address traversal.
REQ-011 REFRESH_MISSED  out  1  sticky flag: a refresh interval elapsed while a refresh was still pending.
REQ-012 TIMEOUT_ERR  out  1  sticky flag: ACK_TIMEOUT expired.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE; all outputs SHALL be registered.
REQ-014 Refresh counter SHALL count down from REFRESH_INTERVAL-1 every cycle; on reaching 0 it SHALL reload and set refresh_pending.
REQ-015 If the counter reaches 0 while refresh_pending=1, REFRESH_MISSED SHALL set; pending stays at 1 (no queueing beyond one).
REQ-016 In IDLE with SDRAM_STATUS=1, the arbiter SHALL select: refresh_pending first, else WRITE_REQ/READ_REQ.
REQ-017 If both WRITE_REQ and READ_REQ are high, the one not served last SHALL win; last_served resets to READ, so write wins first.
REQ-018 In IDLE with SDRAM_STATUS=0 or no request, the FSM SHALL stay in IDLE with CMD_OUT=00.
REQ-019 Selection in cycle N SHALL drive state ISSUE in N+1, with CMD_OUT equal to the selected command for exactly that one cycle.
REQ-020 GRANT_WRITE/GRANT_READ SHALL assert in ISSUE and hold until the cycle after completion; at most one is high at a time; both are 0 for refresh.
REQ-021 WAIT_BUSY: CMD_OUT=00; on SDRAM_STATUS=0 go to WAIT_DONE.
REQ-022 WAIT_BUSY timeout: if SDRAM_STATUS=0 is not seen within ACK_TIMEOUT cycles, set TIMEOUT_ERR, drop grants, and return to IDLE.
REQ-023 After a timeout, no NEXT_* pulse SHALL occur and refresh_pending and last_served SHALL be unchanged, so the request is retried.
REQ-024 WAIT_DONE: on SDRAM_STATUS=1, pulse NEXT_WRITE or NEXT_READ for one cycle (none for refresh), clear refresh_pending if refresh, update last_served, and go to IDLE.
REQ-025 The new request evaluation in IDLE SHALL occur no earlier than the cycle after the NEXT_* pulse, so requester addresses have advanced.
REQ-026 A request deasserting after grant SHALL NOT abort the transaction.
REQ-027 Refresh becoming pending during a read or write SHALL wait for that transaction to complete; no preemption.

Reset
REQ-028 On RESET=1 at a clock edge: state=IDLE; CMD_OUT=00; GRANT_*, NEXT_*, REFRESH_MISSED, TIMEOUT_ERR, refresh_pending = 0; counter = REFRESH_INTERVAL-1; last_served=READ.
REQ-029 RESET asserted mid-transaction SHALL abandon it immediately, with no NEXT_* pulse.

Verification
REQ-030 WRITE_REQ=1 and STATUS=1, with STATUS low 2 cycles after ISSUE and then high -> CMD_OUT=01 for one cycle, GRANT_WRITE held, exactly one NEXT_WRITE pulse.
REQ-031 WRITE_REQ=READ_REQ=1 held continuously -> issued command sequence 01,10,01,10; NEXT pulses alternate.
REQ-032 No requests for 360 cycles after reset, interface cycles normally -> CMD_OUT=11 at cycle 361/362, then no NEXT pulses; repeat 360 cycles later.
REQ-033 STATUS held at 1 after ISSUE -> TIMEOUT_ERR=1 after 8 cycles, FSM returns to IDLE, and the same command is reissued.
REQ-034 STATUS held at 0 for 800 cycles -> REFRESH_MISSED=1 and no commands issued; with STATUS=1 afterward, REFRESH issued first.
REQ-035 RESET pulsed during WAIT_DONE of a read -> all outputs 0 next cycle, no NEXT_READ, and the refresh counter restarts.
